// File: rtl/sync_peak_detect.sv
// Preamble sync peak detector: L1 magnitude of the window sum, threshold trigger, local-max tracking.
// Latency: a valid sample that completes a detection raises sync_det two cycles after it is presented.
// Backpressure: none; ena qualifies each sample and idle cycles freeze all sample-domain state.
//
// Ports:
//   clk       rising-edge clock for all logic
//   rst       synchronous reset, active-low
//   ena       sample valid for sum_Re / sum_Im / thr
//   sum_Re    signed real part of the sliding-window sum
//   sum_Im    signed imaginary part of the sliding-window sum
//   thr       unsigned detection threshold, captured with every valid sample
//   sync_det  one-cycle pulse when a peak is declared
//   peak_idx  sample index of the declared peak, held until the next detection
//   peak_mag  magnitude of the declared peak, held until the next detection
//   busy      high while tracking a candidate peak or holding off after a detection
module sync_peak_detect #(
    parameter int SUM_W    = 22,
    parameter int IDX_W    = 11,
    parameter int PEAK_WIN = 64,
    parameter int HOLD_LEN = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [SUM_W-1:0] sum_Re,
    input  logic [SUM_W-1:0] sum_Im,
    input  logic [SUM_W:0]   thr,
    output logic             sync_det,
    output logic [IDX_W-1:0] peak_idx,
    output logic [SUM_W:0]   peak_mag,
    output logic             busy
);

    // One counter serves both the post-peak window and the hold-off period.
    localparam int CNT_MAX = (PEAK_WIN > HOLD_LEN) ? PEAK_WIN : HOLD_LEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(PEAK_WIN - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [SUM_W:0]   MAG_ONE   = (SUM_W+1)'(1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Sign-extend by one bit before negating so that the most negative input
    // maps to +2^(SUM_W-1) exactly, without saturation.
    function automatic logic [SUM_W:0] abs_ext(input logic [SUM_W-1:0] v);
        logic [SUM_W:0] x;
        x = {v[SUM_W-1], v};
        return v[SUM_W-1] ? (~x + MAG_ONE) : x;
    endfunction

    // Stage 1: magnitude, index and threshold captured together per valid sample.
    logic [SUM_W:0]   mag_r;
    logic [SUM_W:0]   thr_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] smp_cnt;
    logic             mag_v;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mag_r   <= '0;
            thr_r   <= '0;
            idx_r   <= '0;
            smp_cnt <= '0;
            mag_v   <= 1'b0;
        end else begin
            mag_v <= ena;
            if (ena) begin
                mag_r   <= abs_ext(sum_Re) + abs_ext(sum_Im);
                thr_r   <= thr;
                idx_r   <= smp_cnt;
                smp_cnt <= smp_cnt + IDX_ONE;   // wraps modulo 2^IDX_W
            end
        end
    end

    // Stage 2: peak tracking FSM, evaluated only on valid stage-1 results.
    state_t           state;
    state_t           state_nxt;
    logic [SUM_W:0]   pk_mag;
    logic [IDX_W-1:0] pk_idx;
    logic [CNT_W-1:0] cnt;

    logic above_thr;
    logic new_max;

    assign above_thr = (mag_r > thr_r);
    assign new_max   = (mag_r > pk_mag);    // strict: ties keep the earlier index

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (mag_v) begin
            case (state)
                SEARCH:  if (above_thr) state_nxt = TRACK;
                TRACK:   if (!new_max && (cnt == WIN_LAST)) state_nxt = HOLD;
                HOLD:    if (cnt == HOLD_LAST) state_nxt = SEARCH;
                default: state_nxt = SEARCH;
            endcase
        end
    end

    logic pk_load;
    logic cnt_clr;
    logic cnt_inc;
    logic det_fire;

    always_comb begin
        pk_load  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        det_fire = 1'b0;
        if (mag_v) begin
            case (state)
                SEARCH: begin
                    if (above_thr) begin
                        pk_load = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
                TRACK: begin
                    // Falling below the threshold here does not abort the track.
                    if (new_max) begin
                        pk_load = 1'b1;
                        cnt_clr = 1'b1;
                    end else if (cnt == WIN_LAST) begin
                        det_fire = 1'b1;
                        cnt_clr  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) cnt_clr = 1'b1;
                    else                  cnt_inc = 1'b1;
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pk_mag   <= '0;
            pk_idx   <= '0;
            cnt      <= '0;
            sync_det <= 1'b0;
            peak_idx <= '0;
            peak_mag <= '0;
            busy     <= 1'b0;
        end else begin
            sync_det <= det_fire;
            busy     <= (state_nxt != SEARCH);
            if (pk_load) begin
                pk_mag <= mag_r;
                pk_idx <= idx_r;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_ONE;
            end
            if (det_fire) begin
                peak_idx <= pk_idx;
                peak_mag <= pk_mag;
            end
        end
    end

endmodule

// File: tb/tb_sync_peak_detect.sv
module tb_sync_peak_detect;

    localparam int SUM_W = 22;
    localparam int IDX_W = 11;

    logic             clk;
    logic             rst;
    logic             ena;
    logic [SUM_W-1:0] sum_Re;
    logic [SUM_W-1:0] sum_Im;
    logic [SUM_W:0]   thr;
    logic             sync_det;
    logic [IDX_W-1:0] peak_idx;
    logic [SUM_W:0]   peak_mag;
    logic             busy;

    sync_peak_detect #(
        .SUM_W(SUM_W), .IDX_W(IDX_W), .PEAK_WIN(64), .HOLD_LEN(1024)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .sum_Re(sum_Re), .sum_Im(sum_Im), .thr(thr),
        .sync_det(sync_det), .peak_idx(peak_idx), .peak_mag(peak_mag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Detection monitor, sampled on the falling edge.
    int det_cnt = 0;
    int det_cyc = 0;
    int det_idx = 0;
    int det_mag = 0;
    always @(negedge clk) begin
        if (sync_det === 1'b1) begin
            det_cnt <= det_cnt + 1;
            det_cyc <= cyc;
            det_idx <= 32'(peak_idx);
            det_mag <= 32'(peak_mag);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic e, input int re, input int im);
        ena    = e;
        sum_Re = SUM_W'(re);
        sum_Im = SUM_W'(im);
        @(posedge clk);
        #1;
    endtask

    // Mixed-sign split so the L1 magnitude equals m.
    task automatic send_mag(input int m);
        send(1'b1, -(m / 2), m - (m / 2));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) send(1'b1, int'($urandom), int'($urandom));
        rst = 1'b1;
        ena = 1'b0;
    endtask

    function automatic int seq_mag(input int n);
        case (n)
            0, 1:    return 0;
            2:       return 500;
            3:       return 1200;
            4:       return 3000;
            5:       return 2500;
            default: return 2000;
        endcase
    endfunction

    function automatic int t5_mag(input int n);
        if (n <= 68)                return seq_mag(n);
        if (n == 568 || n == 1092)  return 5000;
        if (n == 1093)              return 7000;
        if (n == 2182)              return 9000;
        return 100;
    endfunction

    typedef struct {
        int re;
        int im;
        int thr;
        int exp_det;
        int exp_mag;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        int c;
        int last_c;

        vecs[0] = '{re: -2097152, im: -2097152, thr: 0,       exp_det: 1, exp_mag: 4194304};
        vecs[1] = '{re: 1000,     im: 0,        thr: 1000,    exp_det: 0, exp_mag: 0};
        vecs[2] = '{re: 0,        im: -1,       thr: 0,       exp_det: 1, exp_mag: 1};
        vecs[3] = '{re: -300,     im: 701,      thr: 1000,    exp_det: 1, exp_mag: 1001};
        vecs[4] = '{re: 2097151,  im: -2097152, thr: 4194304, exp_det: 0, exp_mag: 0};
        vecs[5] = '{re: -2097152, im: -2097152, thr: 4194303, exp_det: 1, exp_mag: 4194304};

        rst = 1'b0; ena = 1'b0; sum_Re = '0; sum_Im = '0; thr = '0;

        // Reset held with live, randomly valued samples and a zero threshold.
        do_reset(3);
        chk("rst_sync_det", 32'(sync_det), 0);
        chk("rst_peak_idx", 32'(peak_idx), 0);
        chk("rst_peak_mag", 32'(peak_mag), 0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_no_pulse", 32'(det_cnt),  0);

        // Single peak, continuous ena; first sample after release is index 0.
        thr = 23'd1000;
        base = det_cnt;
        last_c = 0;
        for (int n = 0; n <= 68; n++) begin
            c = cyc;
            send_mag(seq_mag(n));
            last_c = c;
            if (n == 3) chk("t2_busy_before", 32'(busy), 0);
            if (n == 4) chk("t2_busy_track",  32'(busy), 1);
        end
        repeat (5) send_mag(0);
        chk("t2_det_count", 32'(det_cnt - base), 1);
        chk("t2_det_cycle", 32'(det_cyc), 32'(last_c + 2));
        chk("t2_det_idx",   32'(det_idx), 4);
        chk("t2_det_mag",   32'(det_mag), 3000);
        chk("t2_idx_held",  32'(peak_idx), 4);
        chk("t2_busy_hold", 32'(busy), 1);

        // Magnitude / threshold boundary vectors, each followed by a quiet window.
        foreach (vecs[i]) begin
            do_reset(2);
            thr = 23'(vecs[i].thr);
            base = det_cnt;
            send(1'b1, vecs[i].re, vecs[i].im);
            repeat (64) send(1'b1, 0, 0);
            repeat (3) send(1'b0, 0, 0);
            chk($sformatf("vec%0d_det", i),  32'(det_cnt - base), 32'(vecs[i].exp_det));
            chk($sformatf("vec%0d_mag", i),  32'(peak_mag), 32'(vecs[i].exp_mag));
            chk($sformatf("vec%0d_idx", i),  32'(peak_idx), 0);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_det));
        end

        // Same peak with ena toggling 1-0-0-1; idle sums are zero.
        do_reset(2);
        thr = 23'd1000;
        base = det_cnt;
        last_c = 0;
        for (int n = 0; n <= 68; n++) begin
            c = cyc;
            send_mag(seq_mag(n));
            last_c = c;
            if (n == 3) chk("t4_busy_before", 32'(busy), 0);
            send(1'b0, 0, 0);
            if (n == 3) chk("t4_busy_idle", 32'(busy), 1);
            send(1'b0, 0, 0);
        end
        repeat (4) send(1'b0, 0, 0);
        chk("t4_det_count", 32'(det_cnt - base), 1);
        chk("t4_det_cycle", 32'(det_cyc), 32'(last_c + 2));
        chk("t4_det_idx",   32'(det_idx), 4);
        chk("t4_det_mag",   32'(det_mag), 3000);

        // Hold-off, exact re-arm boundary and index wrap.
        do_reset(2);
        thr = 23'd1000;
        base = det_cnt;
        for (int n = 0; n < 2250; n++) begin
            send_mag(t5_mag(n));
            if (n == 70) begin
                chk("t5_det1_count", 32'(det_cnt - base), 1);
                chk("t5_det1_idx",   32'(det_idx), 4);
            end
            if (n == 1092) begin
                chk("t5_ignored_in_hold", 32'(det_cnt - base), 1);
                chk("t5_busy_last_hold",  32'(busy), 1);
            end
            if (n == 1093) chk("t5_busy_rearmed", 32'(busy), 0);
            if (n == 1159) begin
                chk("t5_det2_count", 32'(det_cnt - base), 2);
                chk("t5_det2_idx",   32'(det_idx), 1093);
                chk("t5_det2_mag",   32'(det_mag), 7000);
            end
            if (n == 2248) begin
                chk("t5_det3_count", 32'(det_cnt - base), 3);
                chk("t5_det3_idx",   32'(det_idx), 134);
                chk("t5_det3_mag",   32'(det_mag), 9000);
            end
        end

        // Reset in the middle of a track discards the pending peak.
        do_reset(2);
        thr = 23'd1000;
        base = det_cnt;
        for (int n = 0; n <= 4; n++) send_mag(seq_mag(n));
        repeat (10) send_mag(2000);
        chk("t6_busy_tracking", 32'(busy), 1);
        rst = 1'b0;
        repeat (2) send(1'b0, 0, 0);
        rst = 1'b1;
        chk("t6_busy_after_rst", 32'(busy), 0);
        chk("t6_idx_after_rst",  32'(peak_idx), 0);
        chk("t6_mag_after_rst",  32'(peak_mag), 0);
        send_mag(2000);
        send_mag(2000);                 // tie keeps index 0
        repeat (63) send_mag(1500);
        repeat (3) send(1'b0, 0, 0);
        chk("t6_det_count", 32'(det_cnt - base), 1);
        chk("t6_det_idx",   32'(det_idx), 0);
        chk("t6_det_mag",   32'(det_mag), 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
